// File: rtl/dp_feature_sequencer.sv
// -----------------------------------------------------------------------------
// dp_feature_sequencer
//
// Purpose:
//   Time-multiplexes a feature vector of up to MAX_FEATURES entries onto
//   NUM_MULTS multiplier lanes, one chunk per output handshake. The feature
//   count is supplied at runtime with each vector. It is clamped to
//   MAX_FEATURES. Lanes past the end of the vector carry zero and have their
//   enable cleared. The block sits between the feature register bank and the
//   multiplier array.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      upstream offers a vector
//   in_ready      sequencer is idle and can accept a vector
//   in_data       feature i at [DATA_W*i +: DATA_W]
//   in_num_feat   valid feature count for the offered vector
//   out_valid     a chunk is presented to the multiplier array
//   out_ready     multiplier array accepts the chunk
//   out_data      lane j at [DATA_W*j +: DATA_W]
//   out_lane_en   lane j carries a real feature
//   out_chunk     index of the presented chunk
//   out_last      presented chunk is the final one of the vector
//   busy          a vector is in flight
// -----------------------------------------------------------------------------
module dp_feature_sequencer #(
  parameter  int MAX_FEATURES = 8,
  parameter  int NUM_MULTS    = 4,
  parameter  int DATA_W       = 16,
  localparam int NUM_CHUNKS   = (MAX_FEATURES + NUM_MULTS - 1) / NUM_MULTS,
  localparam int FW           = $clog2(MAX_FEATURES + 1),
  localparam int CW           = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W*MAX_FEATURES-1:0] in_data,
  input  logic [FW-1:0]                  in_num_feat,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W*NUM_MULTS-1:0]    out_data,
  output logic [NUM_MULTS-1:0]           out_lane_en,
  output logic [CW-1:0]                  out_chunk,
  output logic                           out_last,
  output logic                           busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                           r_state;
  state_t                           w_state_next;
  logic [DATA_W*MAX_FEATURES-1:0]   r_vec;
  logic [FW-1:0]                    r_n;
  logic [CW-1:0]                    r_chunk;
  logic [DATA_W*NUM_MULTS-1:0]      r_out_data;
  logic [NUM_MULTS-1:0]             r_out_lane_en;
  logic                             r_out_last;

  logic                             w_accept;
  logic                             w_fire;
  logic [FW-1:0]                    w_n_clamped;
  logic [DATA_W*MAX_FEATURES-1:0]   w_src_vec;
  logic [FW-1:0]                    w_src_n;
  int                               w_beat_chunk;
  logic [DATA_W*NUM_MULTS-1:0]      w_beat_data;
  logic [NUM_MULTS-1:0]             w_beat_en;
  logic                             w_beat_last;

  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_fire      = (r_state == S_SEND) && out_ready;
  assign w_n_clamped = (in_num_feat > FW'(MAX_FEATURES)) ? FW'(MAX_FEATURES) : in_num_feat;

  // The next beat is built from the live input when accepting (chunk 0) and
  // from the latched copy when advancing, so chunk 0 appears one cycle after
  // accept without a separate load cycle.
  assign w_src_vec    = (r_state == S_IDLE) ? in_data     : r_vec;
  assign w_src_n      = (r_state == S_IDLE) ? w_n_clamped : r_n;
  assign w_beat_chunk = (r_state == S_IDLE) ? 0 : int'(r_chunk) + 1;

  // A chunk is last once its lanes reach the feature count, i.e.
  // chunk == ceil(n/NUM_MULTS)-1, evaluated without a divider.
  assign w_beat_last = ((w_beat_chunk + 1) * NUM_MULTS) >= int'(w_src_n);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_beat_data = '0;
    w_beat_en   = '0;
    for (int j = 0; j < NUM_MULTS; j++) begin
      if ((w_beat_chunk * NUM_MULTS + j) < int'(w_src_n) &&
          (w_beat_chunk * NUM_MULTS + j) < MAX_FEATURES) begin
        w_beat_data[DATA_W*j +: DATA_W] =
          w_src_vec[DATA_W*(w_beat_chunk*NUM_MULTS + j) +: DATA_W];
        w_beat_en[j] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && (w_n_clamped != '0)) w_state_next = S_SEND;
      S_SEND: if (w_fire && r_out_last)            w_state_next = S_IDLE;
      default:                                     w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: the vector and count registers are reset too; an aborted vector
  // must leave nothing behind for the next one to see.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec         <= '0;
      r_n           <= '0;
      r_chunk       <= '0;
      r_out_data    <= '0;
      r_out_lane_en <= '0;
      r_out_last    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_vec <= in_data;
            r_n   <= w_n_clamped;
            if (w_n_clamped != '0) begin
              r_chunk       <= '0;
              r_out_data    <= w_beat_data;
              r_out_lane_en <= w_beat_en;
              r_out_last    <= w_beat_last;
            end
          end
        end
        S_SEND: begin
          // Outputs only move on a handshake, so stall holds them stable.
          if (w_fire) begin
            if (r_out_last) begin
              r_chunk       <= '0;
              r_out_data    <= '0;
              r_out_lane_en <= '0;
              r_out_last    <= 1'b0;
            end else begin
              r_chunk       <= r_chunk + CW'(1);
              r_out_data    <= w_beat_data;
              r_out_lane_en <= w_beat_en;
              r_out_last    <= w_beat_last;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_SEND);
  assign busy        = (r_state == S_SEND);
  assign out_data    = r_out_data;
  assign out_lane_en = r_out_lane_en;
  assign out_chunk   = r_chunk;
  assign out_last    = r_out_last;

endmodule

// File: tb/tb_dp_feature_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dp_feature_sequencer
//
// Directed bench for dp_feature_sequencer. One instance uses the default
// 8-feature / 4-lane configuration, a second uses 3 lanes. Features are
// f0..f7 = 16'h0001..16'h0008. Inputs are driven 1 time unit after the
// rising edge and outputs are checked at the same point, clear of the edge.
// -----------------------------------------------------------------------------
module tb_dp_feature_sequencer;

  logic         clk;
  logic         rst_n;

  // Default instance: MAX_FEATURES=8, NUM_MULTS=4, DATA_W=16.
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_num_feat;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [3:0]   out_lane_en;
  logic [0:0]   out_chunk;
  logic         out_last;
  logic         busy;

  // Three-lane instance.
  logic         in_valid3;
  logic         in_ready3;
  logic [3:0]   in_num_feat3;
  logic         out_valid3;
  logic         out_ready3;
  logic [47:0]  out_data3;
  logic [2:0]   out_lane_en3;
  logic [1:0]   out_chunk3;
  logic         out_last3;
  logic         busy3;

  int checks   = 0;
  int failures = 0;
  int hs_count = 0;

  logic [127:0] feat_vec;

  dp_feature_sequencer u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_num_feat (in_num_feat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_lane_en (out_lane_en),
    .out_chunk   (out_chunk),
    .out_last    (out_last),
    .busy        (busy)
  );

  dp_feature_sequencer #(
    .MAX_FEATURES (8),
    .NUM_MULTS    (3),
    .DATA_W       (16)
  ) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid3),
    .in_ready    (in_ready3),
    .in_data     (feat_vec),
    .in_num_feat (in_num_feat3),
    .out_valid   (out_valid3),
    .out_ready   (out_ready3),
    .out_data    (out_data3),
    .out_lane_en (out_lane_en3),
    .out_chunk   (out_chunk3),
    .out_last    (out_last3),
    .busy        (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) hs_count <= hs_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [63:0] data,
                            input logic [3:0] en, input logic chunk, input logic last);
    check({tag, ".valid"}, 64'(out_valid),   64'd1);
    check({tag, ".data"},  out_data,         data);
    check({tag, ".en"},    64'(out_lane_en), 64'(en));
    check({tag, ".chunk"}, 64'(out_chunk),   64'(chunk));
    check({tag, ".last"},  64'(out_last),    64'(last));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"},    64'(out_valid),   64'd0);
    check({tag, ".in_ready"}, 64'(in_ready),    64'd1);
    check({tag, ".busy"},     64'(busy),        64'd0);
    check({tag, ".en"},       64'(out_lane_en), 64'd0);
    check({tag, ".chunk"},    64'(out_chunk),   64'd0);
    check({tag, ".last"},     64'(out_last),    64'd0);
  endtask

  // Offer one vector for one cycle; returns 1 time unit after the accept edge.
  task automatic offer(input logic [3:0] n);
    in_valid    = 1'b1;
    in_num_feat = n;
    tick();
    in_valid    = 1'b0;
  endtask

  localparam logic [63:0] LO8 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] HI8 = 64'h0008_0007_0006_0005;

  initial begin
    for (int i = 0; i < 8; i++) feat_vec[16*i +: 16] = 16'(i + 1);
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = feat_vec;
    in_num_feat  = 4'd0;
    out_ready    = 1'b1;
    in_valid3    = 1'b0;
    in_num_feat3 = 4'd0;
    out_ready3   = 1'b1;

    // Reset state.
    tick();
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.valid",    64'(out_valid), 64'd0);
    check("rst.busy",     64'(busy), 64'd0);
    check("rst.data",     out_data, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full-length vector, no backpressure.
    offer(4'd8);
    check("s1.in_ready", 64'(in_ready), 64'd0);
    check("s1.busy",     64'(busy), 64'd1);
    check_beat("s1.b0", LO8, 4'b1111, 1'b0, 1'b0);
    tick();
    check_beat("s1.b1", HI8, 4'b1111, 1'b1, 1'b1);
    tick();
    check_idle("s1.end");

    // Partial final chunk, then a single short chunk.
    offer(4'd5);
    check_beat("s2a.b0", LO8, 4'b1111, 1'b0, 1'b0);
    tick();
    check_beat("s2a.b1", 64'h0000_0000_0000_0005, 4'b0001, 1'b1, 1'b1);
    tick();
    check_idle("s2a.end");
    offer(4'd3);
    check_beat("s2b.b0", 64'h0000_0003_0002_0001, 4'b0111, 1'b0, 1'b1);
    tick();
    check_idle("s2b.end");

    // Backpressure on beat 0 for three cycles.
    out_ready = 1'b0;
    hs_count  = 0;
    offer(4'd8);
    for (int c = 0; c < 3; c++) begin
      check_beat($sformatf("s3.hold%0d", c), LO8, 4'b1111, 1'b0, 1'b0);
      tick();
    end
    check_beat("s3.hold3", LO8, 4'b1111, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check_beat("s3.b1", HI8, 4'b1111, 1'b1, 1'b1);
    tick();
    check_idle("s3.end");
    check("s3.handshakes", 64'(hs_count), 64'd2);

    // Zero-length vector is dropped.
    offer(4'd0);
    check_idle("s4a.c0");
    tick();
    check_idle("s4a.c1");

    // Over-long count is clamped; input changes during SEND are ignored.
    offer(4'd12);
    in_data     = {8{16'hDEAD}};
    in_num_feat = 4'd1;
    check_beat("s4b.b0", LO8, 4'b1111, 1'b0, 1'b0);
    tick();
    check_beat("s4b.b1", HI8, 4'b1111, 1'b1, 1'b1);
    tick();
    check_idle("s4b.end");
    in_data = feat_vec;

    // Reset in the middle of a stalled beat 0 aborts the vector.
    out_ready = 1'b0;
    offer(4'd8);
    check_beat("s5.pre", LO8, 4'b1111, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("s5.rst.valid",    64'(out_valid), 64'd0);
    check("s5.rst.busy",     64'(busy), 64'd0);
    check("s5.rst.in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    offer(4'd8);
    check_beat("s5.b0", LO8, 4'b1111, 1'b0, 1'b0);
    tick();
    check_beat("s5.b1", HI8, 4'b1111, 1'b1, 1'b1);
    tick();
    check_idle("s5.end");

    // Three-lane configuration, n=8 -> three chunks.
    in_valid3    = 1'b1;
    in_num_feat3 = 4'd8;
    tick();
    in_valid3    = 1'b0;
    check("s6.b0.valid", 64'(out_valid3),   64'd1);
    check("s6.b0.data",  64'(out_data3),    64'h0003_0002_0001);
    check("s6.b0.en",    64'(out_lane_en3), 64'b111);
    check("s6.b0.chunk", 64'(out_chunk3),   64'd0);
    check("s6.b0.last",  64'(out_last3),    64'd0);
    tick();
    check("s6.b1.data",  64'(out_data3),    64'h0006_0005_0004);
    check("s6.b1.en",    64'(out_lane_en3), 64'b111);
    check("s6.b1.chunk", 64'(out_chunk3),   64'd1);
    check("s6.b1.last",  64'(out_last3),    64'd0);
    tick();
    check("s6.b2.data",  64'(out_data3),    64'h0000_0008_0007);
    check("s6.b2.en",    64'(out_lane_en3), 64'b011);
    check("s6.b2.chunk", 64'(out_chunk3),   64'd2);
    check("s6.b2.last",  64'(out_last3),    64'd1);
    tick();
    check("s6.end.valid",    64'(out_valid3), 64'd0);
    check("s6.end.in_ready", 64'(in_ready3),  64'd1);
    check("s6.end.chunk",    64'(out_chunk3), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
